// File: rtl/submodulo_3.sv
// -----------------------------------------------------------------------------
// submodulo_3 : lamp-control FSM fed by the push-button classifier stage.
//
// Automatic mode: the lamp follows presence and turns off after AUTO_SHUTDOWN_T
// cycles without infrared. Manual mode: short presses toggle the lamp, and a
// long press switches between automatic and manual mode.
//
// Optional feature (macro MANUAL_TIMEOUT_EN): manual mode returns to
// automatic mode (lamp off) after MANUAL_RETURN_T cycles without a press.
// That parameter exists only when the macro is defined.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   A        in   long-press level (high while a long press is held)
//   B        in   short-press level (high while a press is debounced, not long)
//   infrared in   presence sensor, synchronous to clk, 1 = presence
//   L        out  lamp drive, 1 = on (registered)
//   D        out  mode indicator, 0 = automatic, 1 = manual (registered)
// -----------------------------------------------------------------------------
module submodulo_3 #(
    parameter int unsigned AUTO_SHUTDOWN_T = 30000
`ifdef MANUAL_TIMEOUT_EN
    ,
    parameter int unsigned MANUAL_RETURN_T = 600000
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic infrared,
    output logic L,
    output logic D
);

    localparam int unsigned TW = 32;
    localparam logic [TW-1:0] AUTO_LIMIT = TW'(AUTO_SHUTDOWN_T - 1);

    typedef enum logic [1:0] {
        AUTO_OFF = 2'd0,
        AUTO_ON  = 2'd1,
        MAN_OFF  = 2'd2,
        MAN_ON   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic            a_q, b_q;
    logic [TW-1:0]   tc_q, tc_d;
    logic            l_q, d_q, l_d, d_d;
    logic            long_ev, short_ev;
    logic            man_timeout;

    // One event per press: rising edge of A, or falling edge of B that is not
    // the short-to-long handover (B drops while A rises in the same cycle).
    assign long_ev  = A & ~a_q;
    assign short_ev = b_q & ~B & ~A;

`ifdef MANUAL_TIMEOUT_EN
    localparam logic [TW-1:0] MAN_LIMIT = TW'(MANUAL_RETURN_T - 1);

    logic [TW-1:0] tm_q, tm_d;

    assign man_timeout = (tm_q >= MAN_LIMIT);

    // Manual inactivity counter: cleared outside manual mode, on state entry
    // and on every short press; saturates instead of wrapping.
    always_comb begin
        tm_d = tm_q;
        if (!state_q[1] || (state_d != state_q) || short_ev) begin
            tm_d = '0;
        end else if (tm_q != '1) begin
            tm_d = tm_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tm_q <= '0;
        end else begin
            tm_q <= tm_d;
        end
    end
`else
    assign man_timeout = 1'b0;
`endif

    // State, history, timer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= AUTO_OFF;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            tc_q    <= '0;
            l_q     <= 1'b0;
            d_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= A;
            b_q     <= B;
            tc_q    <= tc_d;
            l_q     <= l_d;
            d_q     <= d_d;
        end
    end

    // Next-state and timer update; priority long_ev > short_ev > infrared/timer.
    always_comb begin
        state_d = AUTO_OFF;
        tc_d    = (tc_q != '1) ? tc_q + TW'(1) : tc_q;
        case (state_q)
            AUTO_OFF: begin
                if (long_ev) begin
                    state_d = MAN_OFF;
                end else if (infrared) begin
                    state_d = AUTO_ON;
                end else begin
                    state_d = AUTO_OFF;
                end
            end
            AUTO_ON: begin
                if (long_ev) begin
                    state_d = MAN_ON;
                end else if (infrared) begin
                    state_d = AUTO_ON;
                    tc_d    = '0;
                end else if (tc_q >= AUTO_LIMIT) begin
                    state_d = AUTO_OFF;
                end else begin
                    state_d = AUTO_ON;
                end
            end
            MAN_OFF: begin
                if (long_ev) begin
                    state_d = AUTO_OFF;
                end else if (short_ev) begin
                    state_d = MAN_ON;
                end else if (man_timeout) begin
                    state_d = AUTO_OFF;
                end else begin
                    state_d = MAN_OFF;
                end
            end
            MAN_ON: begin
                if (long_ev) begin
                    state_d = AUTO_OFF;
                end else if (short_ev) begin
                    state_d = MAN_OFF;
                end else if (man_timeout) begin
                    state_d = AUTO_OFF;
                end else begin
                    state_d = MAN_ON;
                end
            end
            default: state_d = AUTO_OFF;
        endcase
        // Timer restarts on every state change.
        if (state_d != state_q) begin
            tc_d = '0;
        end
    end

    // Output decode from the next state so L/D update on the same edge.
    always_comb begin
        l_d = 1'b0;
        d_d = 1'b0;
        case (state_d)
            AUTO_ON: l_d = 1'b1;
            MAN_OFF: d_d = 1'b1;
            MAN_ON: begin
                l_d = 1'b1;
                d_d = 1'b1;
            end
            default: begin
                l_d = 1'b0;
                d_d = 1'b0;
            end
        endcase
    end

    assign L = l_q;
    assign D = d_q;

endmodule

// File: tb/tb_submodulo_3.sv
// -----------------------------------------------------------------------------
// tb_submodulo_3 : directed self-checking bench for submodulo_3.
// Runs with AUTO_SHUTDOWN_T=10 (and MANUAL_RETURN_T=20 when MANUAL_TIMEOUT_EN
// is defined). Outputs are compared as the pair {L,D}.
// -----------------------------------------------------------------------------
module tb_submodulo_3;

`ifdef MANUAL_TIMEOUT_EN
    localparam int HOLD = 15;
`else
    localparam int HOLD = 50;
`endif

    logic clk;
    logic rst;
    logic A;
    logic B;
    logic infrared;
    logic L;
    logic D;

    int n_cmp = 0;
    int n_err = 0;

    submodulo_3 #(
        .AUTO_SHUTDOWN_T(10)
`ifdef MANUAL_TIMEOUT_EN
        ,
        .MANUAL_RETURN_T(20)
`endif
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .infrared(infrared),
        .L       (L),
        .D       (D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: {L,D} got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        rst = 1'b1; A = 1'b0; B = 1'b0; infrared = 1'b0;
        tick();
        tick();
        chk("reset", {L, D}, 2'b00);

        // Presence turns the lamp on at the next edge.
        rst = 1'b0;
        infrared = 1'b1;
        tick();
        chk("ir_on", {L, D}, 2'b10);

        // Five presence cycles total, then exactly ten cycles until off.
        for (int i = 0; i < 4; i++) tick();
        infrared = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("shutdown_hold", {L, D}, 2'b10);
        end
        tick();
        chk("shutdown_off", {L, D}, 2'b00);

        // Presence pulse at countdown cycle 7 restarts the count.
        infrared = 1'b1;
        tick();
        chk("ir_reon", {L, D}, 2'b10);
        infrared = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("restart_pre", {L, D}, 2'b10);
        end
        infrared = 1'b1;
        tick();
        chk("restart_pulse", {L, D}, 2'b10);
        infrared = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk("restart_hold", {L, D}, 2'b10);
        end
        tick();
        chk("restart_off", {L, D}, 2'b00);

        // Long press from AUTO_ON keeps the lamp on and enters manual mode.
        infrared = 1'b1;
        tick();
        infrared = 1'b0;
        B = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("pre_long", {L, D}, 2'b10);
        B = 1'b0;
        A = 1'b1;
        tick();
        chk("long_to_man", {L, D}, 2'b11);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("long_held", {L, D}, 2'b11);
        end
        A = 1'b0;
        tick();
        chk("long_release", {L, D}, 2'b11);

        // Short press toggles only on release.
        B = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("short_held", {L, D}, 2'b11);
        end
        B = 1'b0;
        tick();
        chk("short_toggle", {L, D}, 2'b01);

        // Presence is ignored in manual mode.
        infrared = 1'b1;
        tick();
        chk("ir_ignored", {L, D}, 2'b01);
        infrared = 1'b0;

        // Long hold of B: no toggle until release, then exactly one.
        B = 1'b1;
        for (int i = 0; i < HOLD; i++) begin
            tick();
            chk("b_hold", {L, D}, 2'b01);
        end
        B = 1'b0;
        tick();
        chk("hold_release", {L, D}, 2'b11);
        tick();
        chk("single_toggle", {L, D}, 2'b11);

        // Back to MAN_OFF, then short-to-long handover must not toggle.
        B = 1'b1;
        tick();
        B = 1'b0;
        tick();
        chk("to_man_off", {L, D}, 2'b01);
        B = 1'b1;
        tick();
        tick();
        chk("pre_handover", {L, D}, 2'b01);
        B = 1'b0;
        A = 1'b1;
        tick();
        chk("long_exit", {L, D}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_spurious", {L, D}, 2'b00);
        end
        A = 1'b0;
        tick();
        chk("exit_release", {L, D}, 2'b00);

        // Reset coinciding with a short release in MAN_ON.
        A = 1'b1;
        tick();
        chk("auto_off_to_man", {L, D}, 2'b01);
        A = 1'b0;
        tick();
        B = 1'b1;
        tick();
        B = 1'b0;
        tick();
        chk("man_on_again", {L, D}, 2'b11);
        B = 1'b1;
        tick();
        tick();
        B = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_mid", {L, D}, 2'b00);
        rst = 1'b0;
        tick();
        chk("after_rst1", {L, D}, 2'b00);
        tick();
        chk("after_rst2", {L, D}, 2'b00);

        // Manual mode with lamp on, then idle.
        infrared = 1'b1;
        tick();
        infrared = 1'b0;
        A = 1'b1;
        tick();
        chk("man_entry", {L, D}, 2'b11);
        A = 1'b0;
`ifdef MANUAL_TIMEOUT_EN
        for (int i = 1; i <= 19; i++) begin
            tick();
            chk("man_wait", {L, D}, 2'b11);
        end
        tick();
        chk("man_timeout", {L, D}, 2'b00);

        // Short press at cycle 15 restarts the manual timeout.
        infrared = 1'b1;
        tick();
        infrared = 1'b0;
        A = 1'b1;
        tick();
        chk("man_entry2", {L, D}, 2'b11);
        A = 1'b0;
        for (int i = 1; i <= 13; i++) tick();
        B = 1'b1;
        tick();
        chk("tm_pre_short", {L, D}, 2'b11);
        B = 1'b0;
        tick();
        chk("tm_short", {L, D}, 2'b01);
        for (int i = 1; i <= 19; i++) begin
            tick();
            chk("tm_restart_wait", {L, D}, 2'b01);
        end
        tick();
        chk("tm_restart_off", {L, D}, 2'b00);
`else
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk("man_persist", {L, D}, 2'b11);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
